mc_ctrl_fsm: RTL and testbench

- Multicycle main control unit for the MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback states, and drives the datapath strobes and muxes.
- Produces the 3-bit aluop that feeds the downstream ALU-control decoder, which maps aluop + funct to the ALU operation.
- Holds its current state while instruction/data memory is not ready.

---
 rtl/mc_pkg.sv | 66 ++++++
 rtl/mc_ctrl_decode.sv | 81 ++++++++
 rtl/mc_ctrl_fsm.sv | 114 +++++++++++
 tb/tb_mc_ctrl_fsm.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS main control unit: states, opcodes,
// aluop values and datapath mux selects. MC_IMM_OPS_EN adds the immediate-op states.
package mc_pkg;

  localparam int OP_W    = 6;
  localparam int ALUOP_W = 3;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 3'b000;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 3'b001;
  localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 3'b010;
  localparam logic [ALUOP_W-1:0] ALUOP_OR    = 3'b011;
  localparam logic [ALUOP_W-1:0] ALUOP_AND   = 3'b100;

  localparam logic [1:0] ASRCB_REG   = 2'b00;
  localparam logic [1:0] ASRCB_FOUR  = 2'b01;
  localparam logic [1:0] ASRCB_IMM   = 2'b10;
  localparam logic [1:0] ASRCB_BRIMM = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_RTYPE_EX,
    S_RTYPE_WB,
    S_BEQ_EX,
    S_JUMP
`ifdef MC_IMM_OPS_EN
    ,
    S_IMM_EX,
    S_IMM_WB
`endif
  } state_t;

  typedef struct packed {
    logic               pcwrite;
    logic               pcwritecond;
    logic               iord;
    logic               memread;
    logic               memwrite;
    logic               irwrite;
    logic               memtoreg;
    logic               regdst;
    logic               regwrite;
    logic               alusrca;
    logic [1:0]         alusrcb;
    logic [1:0]         pcsource;
    logic [ALUOP_W-1:0] aluop;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// State to control-word mapping for mc_ctrl_fsm; purely combinational, zero latency.
// mem_ready gates only the FETCH irwrite/pcwrite strobes; MC_IMM_OPS_EN adds IMM_EX/IMM_WB.
module mc_ctrl_decode
  import mc_pkg::*;
(
`ifdef MC_IMM_OPS_EN
  input  logic [ALUOP_W-1:0] imm_aluop,
`endif
  input  state_t             state,
  input  logic               mem_ready,
  output ctrl_t              ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.memread  = 1'b1;
        ctrl.alusrcb  = ASRCB_FOUR;
        ctrl.aluop    = ALUOP_ADD;
        ctrl.pcsource = PCSRC_ALU;
        ctrl.irwrite  = mem_ready;
        ctrl.pcwrite  = mem_ready;
      end
      S_DECODE: begin
        // branch target precomputed while the opcode is decoded
        ctrl.alusrcb = ASRCB_BRIMM;
        ctrl.aluop   = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = ASRCB_IMM;
        ctrl.aluop   = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.memread = 1'b1;
        ctrl.iord    = 1'b1;
      end
      S_MEMWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.memwrite = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_RTYPE_EX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = ASRCB_REG;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      S_RTYPE_WB: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = 1'b1;
      end
      S_BEQ_EX: begin
        ctrl.alusrca     = 1'b1;
        ctrl.alusrcb     = ASRCB_REG;
        ctrl.aluop       = ALUOP_SUB;
        ctrl.pcwritecond = 1'b1;
        ctrl.pcsource    = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pcwrite  = 1'b1;
        ctrl.pcsource = PCSRC_JUMP;
      end
`ifdef MC_IMM_OPS_EN
      S_IMM_EX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = ASRCB_IMM;
        ctrl.aluop   = imm_aluop;
      end
      S_IMM_WB: begin
        ctrl.regwrite = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS main control FSM: lw 5, sw/R/imm 4, beq/j 3 cycles, +1 per memory wait.
// Holds FETCH/MEMRD/MEMWR until mem_ready; MC_IMM_OPS_EN enables addi/andi/ori.
module mc_ctrl_fsm
  import mc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [OP_W-1:0]    op,
  input  logic               mem_ready,
  input  logic               zero,
  output logic               pcwrite,
  output logic               pcwritecond,
  output logic               iord,
  output logic               memread,
  output logic               memwrite,
  output logic               irwrite,
  output logic               memtoreg,
  output logic               regdst,
  output logic               regwrite,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsource,
  output logic [ALUOP_W-1:0] aluop,
  output logic               illegal_op
);

  state_t state, state_d;
  logic   illegal;
  ctrl_t  ctrl, ctrl_q;

  // zero qualifies pcwritecond inside the datapath, not here
  logic unused_zero;
  assign unused_zero = zero;

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_d;
  end

`ifdef MC_IMM_OPS_EN
  logic [ALUOP_W-1:0] imm_aluop;

  always_ff @(posedge clk) begin
    if (rst) begin
      imm_aluop <= ALUOP_ADD;
    end else if (state == S_DECODE) begin
      case (op)
        OP_ANDI: imm_aluop <= ALUOP_AND;
        OP_ORI:  imm_aluop <= ALUOP_OR;
        default: imm_aluop <= ALUOP_ADD;
      endcase
    end
  end
`endif

  always_comb begin
    state_d = state;
    illegal = 1'b0;
    case (state)
      S_FETCH: if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPE_EX;
          OP_BEQ:       state_d = S_BEQ_EX;
          OP_J:         state_d = S_JUMP;
`ifdef MC_IMM_OPS_EN
          OP_ADDI, OP_ANDI, OP_ORI: state_d = S_IMM_EX;
`endif
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:    if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:    if (mem_ready) state_d = S_FETCH;
      S_RTYPE_EX: state_d = S_RTYPE_WB;
`ifdef MC_IMM_OPS_EN
      S_IMM_EX:   state_d = S_IMM_WB;
`endif
      default:    state_d = S_FETCH;
    endcase
  end

  mc_ctrl_decode u_decode (
`ifdef MC_IMM_OPS_EN
    .imm_aluop (imm_aluop),
`endif
    .state     (state),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  // reset forces every strobe low so an aborted instruction writes nothing
  assign ctrl_q      = rst ? '0 : ctrl;
  assign illegal_op  = ~rst & illegal;

  assign pcwrite     = ctrl_q.pcwrite;
  assign pcwritecond = ctrl_q.pcwritecond;
  assign iord        = ctrl_q.iord;
  assign memread     = ctrl_q.memread;
  assign memwrite    = ctrl_q.memwrite;
  assign irwrite     = ctrl_q.irwrite;
  assign memtoreg    = ctrl_q.memtoreg;
  assign regdst      = ctrl_q.regdst;
  assign regwrite    = ctrl_q.regwrite;
  assign alusrca     = ctrl_q.alusrca;
  assign alusrcb     = ctrl_q.alusrcb;
  assign pcsource    = ctrl_q.pcsource;
  assign aluop       = ctrl_q.aluop;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: per-instruction cycle sequences are queued
// by the stimulus and compared each cycle by a separate negedge monitor.
module tb_mc_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] op = 6'd0;
  logic       mem_ready = 1'b0;
  logic       zero = 1'b0;
  logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
  logic       memtoreg, regdst, regwrite, alusrca, illegal_op;
  logic [1:0] alusrcb, pcsource;
  logic [2:0] aluop;

  mc_ctrl_fsm dut (
    .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready), .zero(zero),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord),
    .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
    .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .pcsource(pcsource),
    .aluop(aluop), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

`ifdef MC_IMM_OPS_EN
  localparam bit IMM_EN = 1'b1;
`else
  localparam bit IMM_EN = 1'b0;
`endif

  typedef logic [17:0] word_t;

  word_t exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;
  word_t act, mon_exp;
  string mon_tag;

  assign act = {pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg,
                regdst, regwrite, alusrca, alusrcb, pcsource, aluop, illegal_op};

  // Monitor: one expected control word per clock cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_tag = tag_q.pop_front();
      checks++;
      if (act !== mon_exp) begin
        errors++;
        $display("FAIL %s: got %b required %b (pcw pcwc iord mrd mwr irw m2r rdst rwr asa asb pcs aop ill)",
                 mon_tag, act, mon_exp);
      end
    end
  end

  function automatic word_t cw(input bit pcw, input bit pcwc, input bit ab, input bit mrd,
                               input bit mwr, input bit irw, input bit m2r, input bit rdst,
                               input bit rwr, input bit asa, input bit [1:0] asb,
                               input bit [1:0] pcs, input bit [2:0] aop, input bit ill);
    return {pcw, pcwc, ab, mrd, mwr, irw, m2r, rdst, rwr, asa, asb, pcs, aop, ill};
  endfunction

  // Expected control words of each instruction step, taken from the step descriptions
  function automatic word_t w_fetch(input bit go);
    return cw(go, 0, 0, 1, 0, go, 0, 0, 0, 0, 2'b01, 2'b00, 3'b000, 0);
  endfunction
  function automatic word_t w_decode(input bit ill);
    return cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b000, ill);
  endfunction
  function automatic word_t w_immex(input bit [2:0] aop);
    return cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, aop, 0);
  endfunction
  word_t W_MEMADR, W_MEMRD, W_MEMWB, W_MEMWR, W_REX, W_RWB, W_BEQ, W_JUMP, W_IMMWB;
  initial begin
    W_MEMADR = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b000, 0);
    W_MEMRD  = cw(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0);
    W_MEMWB  = cw(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 3'b000, 0);
    W_MEMWR  = cw(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0);
    W_REX    = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b010, 0);
    W_RWB    = cw(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 3'b000, 0);
    W_BEQ    = cw(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b001, 0);
    W_JUMP   = cw(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 3'b000, 0);
    W_IMMWB  = cw(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 3'b000, 0);
  end

  function automatic logic [5:0] rop();
    return 6'($urandom_range(0, 63));
  endfunction
  function automatic bit rbit();
    return 1'($urandom_range(0, 1));
  endfunction
  function automatic bit is_imm(input logic [5:0] o);
    return o == 6'b001000 || o == 6'b001100 || o == 6'b001101;
  endfunction
  function automatic bit legal(input logic [5:0] o);
    return o == 6'b100011 || o == 6'b101011 || o == 6'b000000 || o == 6'b000100 ||
           o == 6'b000010 || (IMM_EN && is_imm(o));
  endfunction

  // Drive one cycle's inputs and queue the control word due in that cycle
  task automatic cyc(input bit r, input logic [5:0] o, input bit mr, input word_t e,
                     input string t);
    rst = r; op = o; mem_ready = mr; zero = rbit();
    exp_q.push_back(e);
    tag_q.push_back(t);
    @(posedge clk); #1;
  endtask

  // Reference sequence of one instruction: fw fetch waits, mw memory waits
  task automatic run_instr(input logic [5:0] o, input int fw, input int mw, input bit abort);
    bit [2:0] iaop;
    for (int i = 0; i < fw; i++) cyc(0, rop(), 0, w_fetch(0), "fetch_wait");
    cyc(0, rop(), 1, w_fetch(1), "fetch");
    cyc(0, o, rbit(), w_decode(!legal(o)), legal(o) ? "decode" : "decode_illegal");
    if (!legal(o)) return;
    if (o == 6'b100011 || o == 6'b101011) begin
      cyc(0, o, rbit(), W_MEMADR, "memadr");
      if (o == 6'b100011) begin
        for (int i = 0; i < mw; i++) cyc(0, rop(), 0, W_MEMRD, "memrd_wait");
        if (abort) begin
          cyc(1, rop(), rbit(), '0, "reset_in_memrd");
          return;
        end
        cyc(0, rop(), 1, W_MEMRD, "memrd");
        cyc(0, rop(), rbit(), W_MEMWB, "memwb");
      end else begin
        for (int i = 0; i < mw; i++) cyc(0, rop(), 0, W_MEMWR, "memwr_wait");
        cyc(0, rop(), 1, W_MEMWR, "memwr");
      end
    end else if (o == 6'b000000) begin
      cyc(0, rop(), rbit(), W_REX, "rtype_ex");
      cyc(0, rop(), rbit(), W_RWB, "rtype_wb");
    end else if (o == 6'b000100) begin
      cyc(0, rop(), rbit(), W_BEQ, "beq_ex");
    end else if (o == 6'b000010) begin
      cyc(0, rop(), rbit(), W_JUMP, "jump");
    end else begin
      iaop = (o == 6'b001100) ? 3'b100 : (o == 6'b001101) ? 3'b011 : 3'b000;
      cyc(0, rop(), rbit(), w_immex(iaop), "imm_ex");
      cyc(0, rop(), rbit(), W_IMMWB, "imm_wb");
    end
  endtask

  logic [5:0] ops [8] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                          6'b000010, 6'b001000, 6'b001100, 6'b001101};

  initial begin
    logic [5:0] o;
    @(posedge clk); #1;
    cyc(1, rop(), rbit(), '0, "reset");
    cyc(1, rop(), rbit(), '0, "reset");

    run_instr(6'b100011, 0, 0, 0);
    run_instr(6'b101011, 0, 3, 0);
    run_instr(6'b000000, 0, 0, 0);
    run_instr(6'b000100, 0, 0, 0);
    run_instr(6'b111111, 0, 0, 0);
    run_instr(6'b001101, 0, 0, 0);
    run_instr(6'b000010, 2, 0, 0);
    run_instr(6'b100011, 0, 1, 1);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 8) == 0) begin
        o = rop();
        while (legal(o)) o = rop();
      end else begin
        o = ops[$urandom_range(0, 7)];
      end
      run_instr(o, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0,
                $urandom_range(0, 15) == 0);
    end

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
